// File: rtl/ad_ip_jesd204_tpl_adc_pn_test_seq_pkg.sv
// rtl/ad_ip_jesd204_tpl_adc_pn_test_seq_pkg.sv - PN link-test sequencer states, PN select codes, sizing helper
package ad_ip_jesd204_tpl_adc_pn_test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCK   = 3'd3,
        ST_DWELL  = 3'd4,
        ST_FINISH = 3'd5
    } pn_test_state_t;

    // pn_seq_sel codes understood by the core's PN monitors
    localparam logic [3:0] PN_SEL_PN9  = 4'h1;
    localparam logic [3:0] PN_SEL_PN23 = 4'h2;
    localparam logic [3:0] PN_SEL_PN15 = 4'h3;
    localparam logic [3:0] PN_SEL_IDLE = 4'hf;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pn_err_acc.sv
// rtl/ad_ip_jesd204_tpl_adc_pn_err_acc.sv - per-channel PN input register, saturating error counter, lock-fail flag
module ad_ip_jesd204_tpl_adc_pn_err_acc #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pn_err,
    input  logic                     pn_oos,
    input  logic                     clear,
    input  logic                     lock_chk,
    input  logic                     count_en,
    output logic                     pn_oos_q,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     lock_fail
);

    logic pn_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pn_err_q  <= 1'b0;
            pn_oos_q  <= 1'b0;
            err_count <= '0;
            lock_fail <= 1'b0;
        end else begin
            pn_err_q <= pn_err;
            pn_oos_q <= pn_oos;
            if (clear) begin
                err_count <= '0;
                lock_fail <= 1'b0;
            end else begin
                if (lock_chk && pn_oos_q)
                    lock_fail <= 1'b1;
                // An out-of-sync cycle is as bad as a bit error; hold at all-ones
                if (count_en && (pn_err_q || pn_oos_q) && (err_count != '1))
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_test_seq.sv
// rtl/ad_ip_jesd204_tpl_adc_pn_test_seq.sv - automatic PN pattern sequencer and per-channel link checker
module ad_ip_jesd204_tpl_adc_pn_test_seq
    import ad_ip_jesd204_tpl_adc_pn_test_seq_pkg::*;
#(
    parameter int                  NUM_CHANNELS  = 1,
    parameter int                  NUM_SEQ       = 2,
    parameter logic [NUM_SEQ*4-1:0] PN_SEQ_LIST  = {PN_SEL_PN23, PN_SEL_PN9},
    parameter logic [3:0]          IDLE_SEL      = PN_SEL_IDLE,
    parameter int                  SETTLE_CYCLES = 16,
    parameter int                  LOCK_TIMEOUT  = 1024,
    parameter int                  DWELL_CYCLES  = 4096,
    parameter int                  ERR_CNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [NUM_CHANNELS-1:0]               chan_mask,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_CHANNELS-1:0]               pass,
    output logic [NUM_CHANNELS-1:0]               lock_fail,
    output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0] err_count,
    output logic [NUM_CHANNELS*4-1:0]             pn_seq_sel,
    input  logic [NUM_CHANNELS-1:0]               pn_err,
    input  logic [NUM_CHANNELS-1:0]               pn_oos
);

    localparam int TMR_MAX = max3(SETTLE_CYCLES, LOCK_TIMEOUT, DWELL_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int SEQ_W   = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;

    pn_test_state_t          state, state_nxt;
    logic [TMR_W-1:0]        tmr;
    logic [SEQ_W-1:0]        k;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [NUM_CHANNELS-1:0] oos_q;
    logic [3:0]              cur_sel;
    logic                    all_locked, last_seq, tmr_zero;
    logic                    acc_clear, lock_chk, count_en, seq_apply, finish_ok;

    assign all_locked = ~|(oos_q & mask_q);
    assign last_seq   = (k == SEQ_W'(NUM_SEQ - 1));
    assign tmr_zero   = (tmr == '0);
    assign cur_sel    = PN_SEQ_LIST[{k, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_APPLY;
                ST_APPLY:  state_nxt = ST_SETTLE;
                ST_SETTLE: if (tmr_zero) state_nxt = ST_LOCK;
                ST_LOCK:   if (all_locked || tmr_zero) state_nxt = ST_DWELL;
                ST_DWELL:  if (tmr_zero) state_nxt = last_seq ? ST_FINISH : ST_APPLY;
                ST_FINISH: state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_clear = 1'b0;
        lock_chk  = 1'b0;
        count_en  = 1'b0;
        seq_apply = 1'b0;
        finish_ok = 1'b0;
        case (state)
            ST_IDLE:   acc_clear = start;
            ST_APPLY:  seq_apply = ~abort;
            ST_LOCK:   lock_chk  = tmr_zero & ~all_locked & ~abort;
            ST_DWELL:  count_en  = ~abort;
            ST_FINISH: finish_ok = ~abort;
            default:   ;
        endcase
    end

    // One down-counter serves every timed state; it is reloaded on each state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                ST_SETTLE: tmr <= TMR_W'(SETTLE_CYCLES - 1);
                ST_LOCK:   tmr <= TMR_W'(LOCK_TIMEOUT - 1);
                ST_DWELL:  tmr <= TMR_W'(DWELL_CYCLES - 1);
                default:   tmr <= '0;
            endcase
        end else if (!tmr_zero) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            mask_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= '0;
            pn_seq_sel <= {NUM_CHANNELS{IDLE_SEL}};
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= finish_ok;
            if (acc_clear) begin
                k      <= '0;
                mask_q <= chan_mask;
                pass   <= '0;
            end else if (state == ST_DWELL && state_nxt == ST_APPLY) begin
                k <= k + SEQ_W'(1);
            end
            if (finish_ok) begin
                for (int i = 0; i < NUM_CHANNELS; i++)
                    pass[i] <= mask_q[i] & ~lock_fail[i] &
                               (err_count[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] == '0);
            end
            if (state_nxt == ST_IDLE) begin
                pn_seq_sel <= {NUM_CHANNELS{IDLE_SEL}};
            end else if (seq_apply) begin
                for (int i = 0; i < NUM_CHANNELS; i++)
                    pn_seq_sel[i*4 +: 4] <= mask_q[i] ? cur_sel : IDLE_SEL;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        ad_ip_jesd204_tpl_adc_pn_err_acc #(
            .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
        ) i_err_acc (
            .clk       (clk),
            .rst       (rst),
            .pn_err    (pn_err[i]),
            .pn_oos    (pn_oos[i]),
            .clear     (acc_clear),
            .lock_chk  (lock_chk & mask_q[i]),
            .count_en  (count_en & mask_q[i]),
            .pn_oos_q  (oos_q[i]),
            .err_count (err_count[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]),
            .lock_fail (lock_fail[i])
        );
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_test_seq.sv
// tb/tb_ad_ip_jesd204_tpl_adc_pn_test_seq.sv - directed self-checking bench for the PN link-test sequencer
module tb_ad_ip_jesd204_tpl_adc_pn_test_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  chan_mask = 2'b00;
    logic [1:0]  pn_err = 2'b00;
    logic [1:0]  pn_oos = 2'b00;
    logic        busy, done;
    logic [1:0]  pass, lock_fail;
    logic [31:0] err_count;
    logic [7:0]  pn_seq_sel;

    logic        start_b = 1'b0;
    logic        abort_b = 1'b0;
    logic [0:0]  chan_mask_b = 1'b0;
    logic [0:0]  pn_err_b = 1'b1;
    logic [0:0]  pn_oos_b = 1'b0;
    logic        busy_b, done_b;
    logic [0:0]  pass_b, lock_fail_b;
    logic [3:0]  err_count_b;
    logic [3:0]  pn_seq_sel_b;

    logic [1:0]  oos_stuck = 2'b00;
    int          oos_cnt [2] = '{1000, 1000};
    logic [3:0]  oos_prev [2] = '{4'hf, 4'hf};
    logic [3:0]  sel_hist0 [$];
    logic [3:0]  sel_hist1 [$];
    logic [3:0]  last0 = 4'hf;
    logic [3:0]  last1 = 4'hf;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_pn_test_seq #(
        .NUM_CHANNELS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .chan_mask  (chan_mask),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .lock_fail  (lock_fail),
        .err_count  (err_count),
        .pn_seq_sel (pn_seq_sel),
        .pn_err     (pn_err),
        .pn_oos     (pn_oos)
    );

    ad_ip_jesd204_tpl_adc_pn_test_seq #(
        .NUM_CHANNELS (1),
        .SETTLE_CYCLES(4),
        .LOCK_TIMEOUT (8),
        .DWELL_CYCLES (32),
        .ERR_CNT_WIDTH(4)
    ) dut_w4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .abort      (abort_b),
        .chan_mask  (chan_mask_b),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b),
        .lock_fail  (lock_fail_b),
        .err_count  (err_count_b),
        .pn_seq_sel (pn_seq_sel_b),
        .pn_err     (pn_err_b),
        .pn_oos     (pn_oos_b)
    );

    // Monitor model: out of sync for 20 cycles after every pattern change, or stuck
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pn_seq_sel[i*4 +: 4] != oos_prev[i]) begin
                oos_prev[i] = pn_seq_sel[i*4 +: 4];
                oos_cnt[i]  = 0;
            end else if (oos_cnt[i] < 1000) begin
                oos_cnt[i]++;
            end
            pn_oos[i] = oos_stuck[i] | (oos_cnt[i] < 20);
        end
        if (pn_seq_sel[3:0] != last0) begin
            last0 = pn_seq_sel[3:0];
            sel_hist0.push_back(last0);
        end
        if (pn_seq_sel[7:4] != last1) begin
            last1 = pn_seq_sel[7:4];
            sel_hist1.push_back(last1);
        end
        if (done)
            done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start_main(input logic [1:0] m);
        @(posedge clk); #1;
        chan_mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_w4(input logic m);
        @(posedge clk); #1;
        chan_mask_b = m;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int max_cyc, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (cyc < max_cyc && !got) begin
            @(posedge clk); #1;
            cyc++;
            got = use_b ? done_b : done;
        end
        @(negedge clk);
    endtask

    initial begin
        int  cyc;
        bit  got;
        int  d0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst lock_fail", lock_fail, 0);
        check("rst err_count", err_count, 0);
        check("rst pn_seq_sel", pn_seq_sel, 8'hff);
        @(posedge clk); #1;
        rst = 1'b0;

        // A: both channels lock quickly, no errors
        sel_hist0.delete();
        sel_hist1.delete();
        d0 = done_cnt;
        start_main(2'b11);
        check("A busy", busy, 1);
        wait_done(1'b0, 20000, cyc, got);
        check("A done", got, 1);
        check("A pass", pass, 2'b11);
        check("A lock_fail", lock_fail, 2'b00);
        check("A err_count", err_count, 32'h0);
        check("A busy after", busy, 0);
        check("A sel idle", pn_seq_sel, 8'hff);
        check("A done pulses", done_cnt - d0, 1);
        check("A hist0 size", sel_hist0.size(), 3);
        if (sel_hist0.size() == 3) begin
            check("A hist0 p0", sel_hist0[0], 4'h1);
            check("A hist0 p1", sel_hist0[1], 4'h2);
            check("A hist0 end", sel_hist0[2], 4'hf);
        end
        check("A hist1 size", sel_hist1.size(), 3);

        // B: ch1 reports errors for 10 cycles inside pattern-0 dwell
        start_main(2'b11);
        repeat (500) @(posedge clk);
        #1 pn_err[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1 pn_err[1] = 1'b0;
        wait_done(1'b0, 20000, cyc, got);
        check("B done", got, 1);
        check("B err1", err_count[31:16], 16'd10);
        check("B err0", err_count[15:0], 16'd0);
        check("B pass", pass, 2'b01);
        check("B lock_fail", lock_fail, 2'b00);

        // C: ch0 never locks; a start while busy must not restart the run
        oos_stuck = 2'b01;
        d0 = done_cnt;
        start_main(2'b11);
        fork
            begin
                repeat (3000) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        wait_done(1'b0, 30000, cyc, got);
        check("C done", got, 1);
        check("C run length", cyc, 2 * (1 + 16 + 1024 + 4096) + 1);
        check("C lock_fail", lock_fail, 2'b01);
        check("C pass", pass, 2'b10);
        check("C err0", err_count[15:0], 16'd8192);
        check("C err1", err_count[31:16], 16'd0);
        check("C done pulses", done_cnt - d0, 1);

        // D: ch0 masked off keeps the idle code and is ignored
        sel_hist0.delete();
        start_main(2'b10);
        wait_done(1'b0, 20000, cyc, got);
        check("D done", got, 1);
        check("D hist0 size", sel_hist0.size(), 0);
        check("D pass", pass, 2'b10);
        check("D lock_fail", lock_fail, 2'b00);
        check("D err0", err_count[15:0], 16'd0);
        oos_stuck = 2'b00;

        // E: abort in the middle of dwell
        d0 = done_cnt;
        start_main(2'b01);
        repeat (2000) @(posedge clk);
        #1 pn_err[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 pn_err[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("E busy", busy, 0);
        check("E sel idle", pn_seq_sel, 8'hff);
        check("E err0 kept", err_count[15:0], 16'd3);
        check("E pass", pass, 2'b00);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("E no done", done_cnt - d0, 0);
        check("E still idle", busy, 0);

        // F: reset while waiting for lock
        oos_stuck = 2'b01;
        d0 = done_cnt;
        start_main(2'b11);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("F busy", busy, 0);
        check("F sel idle", pn_seq_sel, 8'hff);
        check("F lock_fail", lock_fail, 2'b00);
        check("F err_count", err_count, 32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("F no done", done_cnt - d0, 0);
        oos_stuck = 2'b00;

        // G: narrow counter saturates; empty mask still completes
        start_w4(1'b1);
        wait_done(1'b1, 500, cyc, got);
        check("G done", got, 1);
        check("G run length", cyc, 2 * (1 + 4 + 1 + 32) + 1);
        check("G err saturate", err_count_b, 4'hf);
        check("G pass", pass_b, 1'b0);
        check("G lock_fail", lock_fail_b, 1'b0);
        start_w4(1'b0);
        wait_done(1'b1, 500, cyc, got);
        check("G0 done", got, 1);
        check("G0 run length", cyc, 2 * (1 + 4 + 1 + 32) + 1);
        check("G0 pass", pass_b, 1'b0);
        check("G0 err", err_count_b, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
